// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives one outstanding imem request, presents fetched
// words to decode through a one-entry skid buffer, and restarts fetch on redirects.
module fetch_ctrl #(
  parameter logic [31:0] INIT_PC = 32'h0000_0200,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        req_q, req_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        misalign_q, misalign_d;

  logic        accept_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;

  assign accept_s = !stall || !if_valid_q;
  assign target_s = {redirect_pc[31:2], 2'b00};
  assign pc_inc_s = pc_q + 32'd4;

  // Next-state and next-output logic; a redirect overrides stall and ack.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    misalign_d   = redirect_valid && (redirect_pc[1:0] != 2'b00);

    if (redirect_valid) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP;
      case (state_q)
        REQ, KILL: begin
          // Without an ack the old request is still in flight and must be drained.
          if (imem_ack) begin
            pc_d    = target_s;
            state_d = REQ;
          end else begin
            pending_pc_d = target_s;
            state_d      = KILL;
          end
        end
        default: begin
          pc_d    = target_s;
          state_d = REQ;
        end
      endcase
    end else begin
      case (state_q)
        BOOT: begin
          state_d = REQ;
        end
        REQ: begin
          if (imem_ack && accept_s) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
            pc_d       = pc_inc_s;
          end else if (imem_ack) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
            pc_d         = pc_inc_s;
            state_d      = HOLD;
          end else if (accept_s) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP;
          end else begin
            state_d = REQ;
          end
        end
        KILL: begin
          if (imem_ack) begin
            pc_d    = pending_pc_q;
            state_d = REQ;
          end else begin
            state_d = KILL;
          end
          if (accept_s) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP;
          end else begin
            if_valid_d = if_valid_q;
          end
        end
        HOLD: begin
          if (accept_s) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_instr_d = skid_instr_q;
            state_d    = REQ;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end

    req_d = (state_d == REQ) || (state_d == KILL);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= INIT_PC;
      pending_pc_q <= INIT_PC;
      skid_pc_q    <= INIT_PC;
      skid_instr_q <= NOP;
      req_q        <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= INIT_PC;
      if_instr_q   <= NOP;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      req_q        <= req_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a queue-based model of delivered-but-unconsumed
// instructions is compared every cycle, plus directed literal checks.
module tb_fetch_ctrl;

  localparam logic [31:0] INIT_PC = 32'h0000_0200;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign;

  logic ack_ok;
  logic ack_force;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = ack_ok & (imem_req | ack_force);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  fetch_ctrl #(.INIT_PC(INIT_PC), .NOP(NOP)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .misalign      (misalign)
  );

  // Model: queue of {pc, instr} words fetched but not yet taken by decode.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_kill;
  bit          m_boot;
  bit          m_mis;

  function automatic bit m_req();
    return m_boot && (mq.size() < 2);
  endfunction

  task automatic model_init();
    mq.delete();
    m_pc   = INIT_PC;
    m_pend = INIT_PC;
    m_kill = 1'b0;
    m_boot = 1'b0;
    m_mis  = 1'b0;
  endtask

  task automatic model_step();
    bit          req_now;
    bit          ack_now;
    logic [31:0] tgt;
    req_now = m_req();
    ack_now = ack_ok && req_now;
    tgt     = {redirect_pc[31:2], 2'b00};
    if (redirect_valid) begin
      mq.delete();
      if (req_now && !ack_now) begin
        m_kill = 1'b1;
        m_pend = tgt;
      end else begin
        m_pc   = tgt;
        m_kill = 1'b0;
      end
    end else begin
      if (mq.size() > 0 && !stall) void'(mq.pop_front());
      if (ack_now) begin
        if (m_kill) begin
          m_pc   = m_pend;
          m_kill = 1'b0;
        end else begin
          mq.push_back({m_pc, mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    m_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    m_boot = 1'b1;
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_init();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_req", {31'd0, imem_req}, {31'd0, m_req()});
      chk("m_addr", imem_addr, m_pc);
      chk("m_valid", {31'd0, if_valid}, {31'd0, (mq.size() > 0)});
      chk("m_instr", if_instr, (mq.size() > 0) ? mq[0][31:0] : NOP);
      if (mq.size() > 0) chk("m_pc", if_pc, mq[0][63:32]);
      chk("m_misalign", {31'd0, misalign}, {31'd0, m_mis});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0000_0200);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_pc"}, if_pc, 32'h0000_0200);
    chk({tag, "_instr"}, if_instr, 32'h0000_0013);
    chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    ack_ok = 1'b1; ack_force = 1'b1;
    tick(2);
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick(1);
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0000_0200);
    chk("boot_valid", {31'd0, if_valid}, 32'd0);
    ack_force = 1'b0;
    tick(1);
    chk("seq0_pc", if_pc, 32'h0000_0200);
    chk("seq0_instr", if_instr, 32'h1357_99DF);
    chk("seq1_addr", imem_addr, 32'h0000_0204);
    tick(1);
    chk("seq1_pc", if_pc, 32'h0000_0204);
    chk("seq2_addr", imem_addr, 32'h0000_0208);
    stall = 1'b1;
    tick(1);
    chk("stall_pc", if_pc, 32'h0000_0204);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    tick(2);
    chk("stall3_pc", if_pc, 32'h0000_0204);
    chk("stall3_valid", {31'd0, if_valid}, 32'd1);
    stall = 1'b0;
    tick(1);
    chk("skid_pc", if_pc, 32'h0000_0208);
    chk("skid_addr", imem_addr, 32'h0000_020C);
    tick(1);
    chk("after_skid_pc", if_pc, 32'h0000_020C);
    chk("after_skid_addr", imem_addr, 32'h0000_0210);
    ack_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    tick(1);
    chk("kill_valid", {31'd0, if_valid}, 32'd0);
    chk("kill_addr", imem_addr, 32'h0000_0210);
    chk("kill_instr", if_instr, 32'h0000_0013);
    redirect_valid = 1'b0;
    tick(1);
    chk("kill2_addr", imem_addr, 32'h0000_0210);
    ack_ok = 1'b1;
    tick(1);
    chk("kill_done_addr", imem_addr, 32'h0000_0400);
    chk("kill_done_valid", {31'd0, if_valid}, 32'd0);
    tick(1);
    chk("tgt_pc", if_pc, 32'h0000_0400);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    tick(1);
    chk("rdack_valid", {31'd0, if_valid}, 32'd0);
    chk("rdack_addr", imem_addr, 32'h0000_0400);
    redirect_valid = 1'b0;
    tick(1);
    chk("rdack_next_pc", if_pc, 32'h0000_0400);
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0402;
    tick(1);
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_addr", imem_addr, 32'h0000_0400);
    redirect_valid = 1'b0;
    tick(1);
    chk("mis_end", {31'd0, misalign}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(1);
    chk("wrap_start", imem_addr, 32'hFFFF_FFF8);
    redirect_valid = 1'b0;
    tick(2);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    ack_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick(1);
    chk("kill_req", {31'd0, imem_req}, 32'd1);
    chk("kill_hold_addr", imem_addr, 32'h0000_0000);
    redirect_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_outputs("async");
    ack_force = 1'b1; ack_ok = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("reboot_req", {31'd0, imem_req}, 32'd1);
    chk("reboot_addr", imem_addr, 32'h0000_0200);
    ack_force = 1'b0;

    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom_range(0, 2) == 0);
      ack_ok         = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 32'h0000_1000 | $urandom_range(0, 1023);
      tick(1);
    end

    stall = 1'b0; ack_ok = 1'b1; redirect_valid = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0601;
    tick(1);
    chk("bootrd_addr", imem_addr, 32'h0000_0600);
    chk("bootrd_mis", {31'd0, misalign}, 32'd1);
    redirect_valid = 1'b0;
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
